// File: rtl/alu_serial_deserializer_pkg.sv
// Shared definitions for the ALU serial command link: opcodes, error-flag
// positions, frame length and CRC polynomial.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_e;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam int FRAME_LEN = 11;

  // x^4 + x + 1, x^4 term implicit
  localparam logic [3:0] CRC_POLY = 4'h3;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/alu_serial_deserializer_if.sv
// Command bus between the serial deserializer (master) and the ALU core (slave).
interface alu_serial_deserializer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        cmd_err;
  logic [2:0]  cmd_err_flags;
  logic        cmd_ovf;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_err, cmd_err_flags, cmd_ovf,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_err, cmd_err_flags, cmd_ovf,
    output cmd_ready
  );
endinterface

// File: rtl/alu_serial_deserializer_crc4.sv
// Bit-serial CRC-4 (x^4+x+1, init 0). Only built when ALU_DESER_CRC_CHECK_EN
// is defined; the default build carries no CRC logic.
`ifdef ALU_DESER_CRC_CHECK_EN
module alu_crc4_serial
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);
  logic w_fb;

  assign w_fb = din ^ crc[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[2:0], 1'b0} ^ ({4{w_fb}} & CRC_POLY);
    end
  end
endmodule
`endif

// File: rtl/alu_serial_deserializer.sv
// Receive end of the ALU serial command link: frames -> command -> valid/ready.
// Optional CRC check enabled by defining ALU_DESER_CRC_CHECK_EN.
module alu_serial_deserializer
  import alu_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CRC_W      = 4
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sin,
  alu_serial_deserializer_if.master   cmd
);
  // state   | meaning
  // S_IDLE  | waiting for a start bit (only once armed)
  // S_FRAME | shifting bits 1..10 of a frame
  // S_DONE  | control frame received; evaluate and load output
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int CNT_W = $clog2(DATA_BYTES + 2);

  logic [1:0]       r_state;
  logic [3:0]       r_bit_cnt;
  logic             r_armed;
  logic             r_ctl;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [63:0]      r_asm;
  logic [CRC_W+2:0] r_ctl_byte;

  logic       w_data_bit;
  logic       w_stop_bit;
  logic       w_done;
  logic [2:0] w_op;
  logic       w_err_data;
  logic       w_err_crc;
  logic       w_err_op;
  logic [2:0] w_flags;

  assign w_data_bit = (r_state == S_FRAME) && (r_bit_cnt >= 4'd2) && (r_bit_cnt <= 4'd9);
  assign w_stop_bit = (r_state == S_FRAME) && (r_bit_cnt == 4'(FRAME_LEN - 1));
  assign w_done     = (r_state == S_DONE);
  assign w_op       = r_ctl_byte[CRC_W+2 -: 3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_armed     <= 1'b0;
      r_ctl       <= 1'b0;
      r_frame_err <= 1'b0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_ctl_byte  <= '0;
    end else begin
      if (sin) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!sin && r_armed) begin
            r_state   <= S_FRAME;
            r_bit_cnt <= 4'd1;
          end
        end
        S_FRAME: begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd1) begin
            r_ctl <= sin;
          end else if (w_data_bit) begin
            // control byte keeps only its low 7 bits: {op, crc}
            if (r_ctl) r_ctl_byte <= {r_ctl_byte[CRC_W+1:0], sin};
            else       r_asm      <= {r_asm[62:0], sin};
          end else if (w_stop_bit) begin
            if (!sin) r_frame_err <= 1'b1;
            if (r_ctl) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
              if (r_byte_cnt != CNT_W'(DATA_BYTES + 1)) r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_byte_cnt  <= '0;
          r_frame_err <= 1'b0;
          r_asm       <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_err_data = (r_byte_cnt != CNT_W'(DATA_BYTES)) || r_frame_err;

`ifdef ALU_DESER_CRC_CHECK_EN
  logic [CRC_W-1:0] w_crc;
  logic             w_crc_en;
  logic             w_crc_din;

  // control frame feeds a fixed 1 in place of its leading 0, then op, and stops
  assign w_crc_en  = w_data_bit && (!r_ctl || (r_bit_cnt <= 4'd5));
  assign w_crc_din = (r_ctl && (r_bit_cnt == 4'd2)) ? 1'b1 : sin;

  alu_crc4_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_done),
    .en    (w_crc_en),
    .din   (w_crc_din),
    .crc   (w_crc)
  );

  assign w_err_crc = !w_err_data && (w_crc != r_ctl_byte[CRC_W-1:0]);
`else
  assign w_err_crc = 1'b0;
`endif

  assign w_err_op = !w_err_data && !w_err_crc && !op_is_legal(w_op);

  always_comb begin
    w_flags               = '0;
    w_flags[ERR_DATA_BIT] = w_err_data;
    w_flags[ERR_CRC_BIT]  = w_err_crc;
    w_flags[ERR_OP_BIT]   = w_err_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd.cmd_valid     <= 1'b0;
      cmd.cmd_a         <= '0;
      cmd.cmd_b         <= '0;
      cmd.cmd_op        <= '0;
      cmd.cmd_err       <= 1'b0;
      cmd.cmd_err_flags <= '0;
      cmd.cmd_ovf       <= 1'b0;
    end else begin
      cmd.cmd_ovf <= 1'b0;
      if (w_done) begin
        if (!cmd.cmd_valid || cmd.cmd_ready) begin
          cmd.cmd_valid     <= 1'b1;
          cmd.cmd_a         <= r_asm[31:0];
          cmd.cmd_b         <= r_asm[63:32];
          cmd.cmd_op        <= w_op;
          cmd.cmd_err       <= |w_flags;
          cmd.cmd_err_flags <= w_flags;
        end else begin
          cmd.cmd_ovf <= 1'b1;
        end
      end else if (cmd.cmd_ready) begin
        cmd.cmd_valid <= 1'b0;
      end
    end
  end

endmodule
